groestl_scan_ctrl: RTL and testbench

- Sequencer for the fully pipelined, fixed-latency, stall-free groestl512 core.
- Accepts one work unit per transaction: 480-bit header template, nonce range and 64-bit target.
- Issues one nonce per cycle into the core and tracks in-flight nonces with a tag shift register matched to core latency.
- Compares each returned hash against the target; pushes winning nonces into a small result FIFO drained by the host interface.

---
 rtl/groestl_scan_ctrl_pkg.sv | 21 ++
 rtl/groestl_scan_ctrl_fifo.sv | 62 ++++++
 rtl/groestl_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_groestl_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/groestl_scan_ctrl_pkg.sv
// Shared types and constants for the groestl512 nonce-scan sequencer.
package groestl_ctrl_pkg;

  localparam int DEF_NONCE_W = 32;

  // Slice of the hash compared against the target (most significant word).
  localparam int HIT_MSB = 511;
  localparam int HIT_LSB = 448;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic [DEF_NONCE_W-1:0] nonce;
  } tag_t;

endpackage

// File: rtl/groestl_scan_ctrl_fifo.sv
// Small synchronous result FIFO with show-ahead head output.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module scan_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head is read combinationally so res_nonce is valid alongside res_valid.
  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/groestl_scan_ctrl.sv
// Nonce-scan sequencer for a fixed-latency, stall-free groestl512 core:
// issues one nonce per cycle, tracks in-flight nonces and queues hits.
module groestl_scan_ctrl
  import groestl_ctrl_pkg::*;
#(
  parameter int HASH_LATENCY = 46,
  parameter int NONCE_W      = DEF_NONCE_W,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               work_valid,
  output logic               work_ready,
  input  logic [479:0]       work_header,
  input  logic [NONCE_W-1:0] work_start,
  input  logic [NONCE_W-1:0] work_end,
  input  logic [63:0]        work_target,
  input  logic               abort,
  output logic [511:0]       core_block,
  input  logic [511:0]       core_hash,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NONCE_W-1:0] res_nonce,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [NONCE_W-1:0] cur_nonce
);

  state_t                  state_reg, state_next;
  logic [479:0]            header_reg;
  logic [NONCE_W-1:0]      end_reg;
  logic [NONCE_W-1:0]      cur_nonce_reg;
  logic [63:0]             target_reg;
  logic [511:0]            core_block_reg;
  logic                    overflow_reg;

  tag_t                    tag_reg [HASH_LATENCY];
  tag_t                    tag_in;
  tag_t                    tag_out;
  logic [HASH_LATENCY-1:0] tag_valid_vec;
  logic                    in_flight;

  logic                    accept;
  logic                    issue;
  logic                    hit;
  logic                    pop;
  logic                    drop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                    unused_bits;

  assign accept = (state_reg == IDLE) && work_valid;

  always_comb begin
    state_next   = state_reg;
    issue        = 1'b0;
    tag_in.valid = 1'b0;
    tag_in.nonce = cur_nonce_reg;
    case (state_reg)
      IDLE: begin
        if (work_valid) state_next = SCAN;
      end
      SCAN: begin
        if (abort) begin
          state_next = DRAIN;
        end else begin
          issue        = 1'b1;
          tag_in.valid = 1'b1;
          if (cur_nonce_reg == end_reg) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!in_flight) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      header_reg     <= '0;
      end_reg        <= '0;
      target_reg     <= '0;
      cur_nonce_reg  <= '0;
      core_block_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        header_reg    <= work_header;
        end_reg       <= work_end;
        target_reg    <= work_target;
        cur_nonce_reg <= work_start;
        overflow_reg  <= 1'b0;
      end
      if (issue) begin
        core_block_reg <= {header_reg, cur_nonce_reg};
        cur_nonce_reg  <= cur_nonce_reg + NONCE_W'(1);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Tag line mirrors the core pipeline so each hash meets its nonce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HASH_LATENCY; i++) tag_reg[i] <= '0;
    end else begin
      tag_reg[0] <= tag_in;
      for (int i = 1; i < HASH_LATENCY; i++) tag_reg[i] <= tag_reg[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < HASH_LATENCY; gi++) begin : g_tag_valid
      assign tag_valid_vec[gi] = tag_reg[gi].valid;
    end
  endgenerate

  assign in_flight = |tag_valid_vec;
  assign tag_out   = tag_reg[HASH_LATENCY-1];

  // Hash is only trusted when the tag says a real nonce is emerging.
  assign hit  = tag_out.valid && (core_hash[HIT_MSB:HIT_LSB] <= target_reg);
  assign pop  = res_ready && !fifo_empty;
  assign drop = hit && fifo_full && !pop;

  scan_result_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (hit),
    .push_data (tag_out.nonce),
    .pop       (pop),
    .head      (res_nonce),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign unused_bits = ^{core_hash[HIT_LSB-1:0], fifo_count};

  assign work_ready = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DRAIN) && !in_flight;
  assign res_valid  = !fifo_empty;
  assign overflow   = overflow_reg;
  assign core_block = core_block_reg;
  assign cur_nonce  = cur_nonce_reg;

endmodule

// File: tb/tb_groestl_scan_ctrl.sv
// Directed bench for groestl_scan_ctrl with a fixed-hash stub core.
module tb_groestl_scan_ctrl;

  localparam int L     = 46;
  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic         work_valid;
  logic         work_ready;
  logic [479:0] work_header;
  logic [31:0]  work_start;
  logic [31:0]  work_end;
  logic [63:0]  work_target;
  logic         abort;
  logic [511:0] core_block;
  logic [511:0] core_hash;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [31:0]  cur_nonce;

  groestl_scan_ctrl #(
    .HASH_LATENCY (L),
    .NONCE_W      (32),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .work_valid  (work_valid),
    .work_ready  (work_ready),
    .work_header (work_header),
    .work_start  (work_start),
    .work_end    (work_end),
    .work_target (work_target),
    .abort       (abort),
    .core_block  (core_block),
    .core_hash   (core_hash),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_nonce   (res_nonce),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .cur_nonce   (cur_nonce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start;
    logic [31:0] fin;
    logic [63:0] target;
    logic [63:0] htop;
    int          abort_at;
    int          n_iss;
    int          n_hit;
    logic [31:0] cur;
  } vec_t;

  vec_t         vecs [8];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [31:0]  iss_q [$];
  int           iss_cyc [$];
  int           done_cyc [$];
  logic [31:0]  pop_q [$];
  int           pop_cyc [$];
  logic [511:0] last_blk = '0;
  logic [447:0] hash_low;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log issues (core_block changes), done pulses and pops.
  always @(negedge clk) begin
    if (core_block !== last_blk) begin
      iss_q.push_back(core_block[31:0]);
      iss_cyc.push_back(cyc);
      last_blk = core_block;
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      pop_q.push_back(res_nonce);
      pop_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    iss_q.delete();
    iss_cyc.delete();
    done_cyc.delete();
    pop_q.delete();
    pop_cyc.delete();
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done_cyc.size() == 0 && n < 400) begin
      tick();
      n++;
    end
    chk(nm, done_cyc.size(), 1);
  endtask

  task automatic accept_job(input logic [31:0] hw, input logic [31:0] s, input logic [31:0] e,
                            input logic [63:0] tgt, input logic [63:0] htop);
    int n;
    work_header = {15{hw}};
    work_start  = s;
    work_end    = e;
    work_target = tgt;
    core_hash   = {htop, hash_low};
    clear_logs();
    n = 0;
    while (!work_ready && n < 100) begin
      tick();
      n++;
    end
    work_valid = 1'b1;
    tick();
    work_valid = 1'b0;
  endtask

  task automatic run_job(input vec_t v, input int idx);
    logic [31:0] hw;
    logic [31:0] e;
    hw = 32'hA500_0000 | 32'(idx);
    accept_job(hw, v.start, v.fin, v.target, v.htop);
    chk($sformatf("v%0d_busy", idx), busy, 1);
    if (v.abort_at >= 0) begin
      repeat (v.abort_at) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    wait_done($sformatf("v%0d_done_seen", idx));
    chk($sformatf("v%0d_ready_after_done", idx), work_ready, 1);
    tick();
    tick();
    chk($sformatf("v%0d_n_issue", idx), iss_q.size(), v.n_iss);
    for (int i = 0; i < iss_q.size() && i < v.n_iss; i++) begin
      e = v.start + 32'(i);
      chk($sformatf("v%0d_issue%0d", idx, i), iss_q[i], e);
    end
    chk($sformatf("v%0d_n_hit", idx), pop_q.size(), v.n_hit);
    for (int i = 0; i < pop_q.size() && i < v.n_hit; i++) begin
      e = v.start + 32'(i);
      chk($sformatf("v%0d_hit%0d", idx, i), pop_q[i], e);
    end
    chk($sformatf("v%0d_done_count", idx), done_cyc.size(), 1);
    if (done_cyc.size() > 0 && iss_cyc.size() > 0)
      chk($sformatf("v%0d_done_latency", idx), done_cyc[0] - iss_cyc[iss_cyc.size()-1], L);
    if (pop_cyc.size() > 0 && iss_cyc.size() > 0)
      chk($sformatf("v%0d_hit_latency", idx), pop_cyc[0] - iss_cyc[0], L);
    chk($sformatf("v%0d_cur_nonce", idx), cur_nonce, v.cur);
    chk($sformatf("v%0d_hdr_lo", idx), core_block[63:32], hw);
    chk($sformatf("v%0d_hdr_hi", idx), core_block[511:480], hw);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pops [6];
    hash_low = {14{32'hDEAD_BEEF}};

    //          start          fin            target                  htop                    abort iss hit cur
    vecs[0] = '{32'h10,        32'h10,        64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  -1, 1, 1, 32'h11};
    vecs[1] = '{32'h0,         32'h3,         64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, -1, 4, 4, 32'h4};
    vecs[2] = '{32'h0,         32'h3,         64'h0,                  64'h1,                  -1, 4, 0, 32'h4};
    vecs[3] = '{32'h7,         32'h8,         64'h5,                  64'h5,                  -1, 2, 2, 32'h9};
    vecs[4] = '{32'h7,         32'h8,         64'h5,                  64'h6,                  -1, 2, 0, 32'h9};
    vecs[5] = '{32'hFFFF_FFFE, 32'h1,         64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  -1, 4, 4, 32'h2};
    vecs[6] = '{32'h0,         32'd99,        64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   3, 3, 3, 32'h3};
    vecs[7] = '{32'h100,       32'h102,       64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, -1, 3, 3, 32'h103};

    rst_n       = 1'b0;
    work_valid  = 1'b0;
    work_header = '0;
    work_start  = '0;
    work_end    = '0;
    work_target = '0;
    abort       = 1'b0;
    res_ready   = 1'b1;
    core_hash   = {64'h0, hash_low};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_work_ready", work_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_core_block_lo", core_block[63:0], 0);
    chk("rst_cur_nonce", cur_nonce, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_job(vecs[i], i);

    // Overflow: six all-hit nonces into a 4-deep FIFO with no popping.
    res_ready = 1'b0;
    accept_job(32'hB100_0001, 32'h0, 32'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    wait_done("ovf_done_seen");
    chk("ovf_flag", overflow, 1);
    chk("ovf_res_valid", res_valid, 1);
    chk("ovf_head", res_nonce, 0);
    chk("ovf_no_pops", pop_q.size(), 0);

    // Pop and push coincide on a full FIFO: both hits must be accepted.
    accept_job(32'hB100_0002, 32'h20, 32'h21, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    chk("ovf2_cleared_on_accept", overflow, 0);
    chk("ovf2_fifo_kept", res_valid, 1);
    repeat (L) tick();
    res_ready = 1'b1;
    tick();
    tick();
    res_ready = 1'b0;
    wait_done("ovf2_done_seen");
    chk("ovf2_no_drop", overflow, 0);
    res_ready = 1'b1;
    repeat (6) tick();
    exp_pops = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h20, 32'h21};
    chk("ovf2_n_pops", pop_q.size(), 6);
    for (int i = 0; i < pop_q.size() && i < 6; i++)
      chk($sformatf("ovf2_pop%0d", i), pop_q[i], exp_pops[i]);
    chk("ovf2_empty", res_valid, 0);

    // Reset in mid-SCAN with a full FIFO and overflow already set.
    res_ready = 1'b0;
    accept_job(32'hC100_0001, 32'h0, 32'd99, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    repeat (L + 8) tick();
    chk("mid_busy", busy, 1);
    chk("mid_overflow", overflow, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_res_valid", res_valid, 0);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_work_ready", work_ready, 1);
    chk("mrst_cur_nonce", cur_nonce, 0);
    chk("mrst_core_block", core_block[63:0], 0);
    tick();
    tick();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    tick();
    run_job(vecs[0], 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
